// File: rtl/datasram_resp.sv
// Data SRAM front end: a core request FIFO and a host port share one single-port SRAM.
// The host has fixed priority. Read data returns one cycle after issue to whichever side issued it.
module datasram_resp #(
  parameter int unsigned AW    = 13,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   datasram_ctrl,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          err_overflow,
  output logic          err_conflict
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] q_addr  [DEPTH];
  logic [DW-1:0] q_wdata [DEPTH];
  logic [DEPTH-1:0] q_we;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic core_pend, host_pend;

  logic core_rd, core_wr, core_req, conflict;
  logic empty, full, host_issue, core_issue, push, drop;
  logic ctrl_unused;

  assign ctrl_unused = datasram_ctrl[15];
  assign core_rd     = datasram_ctrl[13];
  assign core_wr     = datasram_ctrl[14];
  assign core_req    = core_rd ^ core_wr;
  assign conflict    = core_rd & core_wr;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Issue is gated by rst_n so every SRAM-side output is quiet while reset is held.
  // The FIFO is never empty-bypassed, so a request pushed this cycle cannot issue before the next.
  assign host_issue = rst_n & host_req;
  assign core_issue = rst_n & ~host_req & ~empty;
  assign push       = core_req & (~full | core_issue);
  assign drop       = core_req & full & ~core_issue;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= datasram_ctrl[AW-1:0];
      q_wdata[wr_ptr] <= core_wdata;
      q_we[wr_ptr]    <= core_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      core_pend    <= 1'b0;
      host_pend    <= 1'b0;
      err_overflow <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PW'(1);
      if (core_issue) rd_ptr <= rd_ptr + PW'(1);
      case ({push, core_issue})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      core_pend <= core_issue & ~q_we[rd_ptr];
      host_pend <= host_issue & ~host_we;
      if (drop)     err_overflow <= 1'b1;
      if (conflict) err_conflict <= 1'b1;
    end
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (host_issue) begin
      sram_ce    = 1'b1;
      sram_we    = host_we;
      sram_addr  = host_addr;
      sram_wdata = host_wdata;
    end else if (core_issue) begin
      sram_ce    = 1'b1;
      sram_we    = q_we[rd_ptr];
      sram_addr  = q_addr[rd_ptr];
      sram_wdata = q_wdata[rd_ptr];
    end
  end

  assign host_gnt    = host_issue;
  assign core_stall  = full;
  assign core_rvalid = core_pend;
  assign host_rvalid = host_pend;
  assign core_rdata  = core_pend ? sram_rdata : '0;
  assign host_rdata  = host_pend ? sram_rdata : '0;

endmodule

// File: tb/tb_datasram_resp.sv
// Bench for datasram_resp: SRAM behavioural model, queue-based reference model,
// table vectors, directed corner sequences and randomized traffic.
module tb_datasram_resp;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0]   datasram_ctrl;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_rvalid, core_stall;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr, sram_addr;
  logic [DW-1:0] host_wdata, host_rdata, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          sram_ce, sram_we, err_overflow, err_conflict;

  int errors = 0;
  int checks = 0;

  datasram_resp #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .datasram_ctrl(datasram_ctrl), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .err_overflow(err_overflow), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  // SRAM macro: read data valid the cycle after a read issue
  logic [DW-1:0] mem [8192];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  // Reference model: ordered queue of accepted core requests plus a shadow memory
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;
  req_t q[$];
  logic [DW-1:0] ref_mem [8192];
  logic m_core_rv, m_host_rv, m_ovf, m_cfl;
  logic [DW-1:0] m_core_d, m_host_d;

  typedef struct {
    logic [15:0]   ctrl;
    logic [DW-1:0] wdata;
    logic          e_ce;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rv;
    logic [DW-1:0] e_rdata;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_core_rv = 1'b0;
    m_host_rv = 1'b0;
    m_core_d  = '0;
    m_host_d  = '0;
    m_ovf     = 1'b0;
    m_cfl     = 1'b0;
  endtask

  task automatic model_check();
    logic e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (rst_n && host_req) begin
      e_ce = 1'b1; e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
    end else if (rst_n && q.size() > 0) begin
      e_ce = 1'b1; e_we = q[0].we; e_addr = q[0].addr; e_wd = q[0].wdata;
    end
    chk("m_sram_ce", sram_ce, e_ce);
    chk("m_sram_we", sram_we, e_we);
    chk("m_sram_addr", sram_addr, e_addr);
    if (!e_ce || e_we) chk("m_sram_wdata", sram_wdata, e_wd);
    chk("m_host_gnt", host_gnt, rst_n & host_req);
    chk("m_core_stall", core_stall, q.size() == DEPTH);
    chk("m_core_rvalid", core_rvalid, m_core_rv);
    if (m_core_rv) chk("m_core_rdata", core_rdata, m_core_d);
    chk("m_host_rvalid", host_rvalid, m_host_rv);
    if (m_host_rv) chk("m_host_rdata", host_rdata, m_host_d);
    chk("m_err_overflow", err_overflow, m_ovf);
    chk("m_err_conflict", err_conflict, m_cfl);
  endtask

  task automatic model_advance();
    req_t r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_core_rv = 1'b0;
    m_host_rv = 1'b0;
    if (host_req) begin
      if (host_we) ref_mem[host_addr] = host_wdata;
      else begin m_host_rv = 1'b1; m_host_d = ref_mem[host_addr]; end
    end else if (q.size() > 0) begin
      r = q.pop_front();
      if (r.we) ref_mem[r.addr] = r.wdata;
      else begin m_core_rv = 1'b1; m_core_d = ref_mem[r.addr]; end
    end
    if (datasram_ctrl[13] && datasram_ctrl[14]) m_cfl = 1'b1;
    else if (datasram_ctrl[13] || datasram_ctrl[14]) begin
      if (q.size() < DEPTH) begin
        r.we = datasram_ctrl[14]; r.addr = datasram_ctrl[AW-1:0]; r.wdata = core_wdata;
        q.push_back(r);
      end else m_ovf = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_in(input logic [15:0] c, input logic [DW-1:0] wd, input logic hr,
                        input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    datasram_ctrl = c; core_wdata = wd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  initial begin
    logic [DW-1:0] got [$];
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    vecs[0] = '{16'h4010, 16'h1234, 1'b1, 1'b1, 13'h0010, 16'h1234, 1'b0, 16'h0000};
    vecs[1] = '{16'h2010, 16'h0000, 1'b1, 1'b0, 13'h0010, 16'h0000, 1'b1, 16'h1234};
    vecs[2] = '{16'h4005, 16'hBEEF, 1'b1, 1'b1, 13'h0005, 16'hBEEF, 1'b0, 16'h0000};
    vecs[3] = '{16'h2005, 16'h0000, 1'b1, 1'b0, 13'h0005, 16'h0000, 1'b1, 16'hBEEF};
    vecs[4] = '{16'h5fff, 16'hA5A5, 1'b1, 1'b1, 13'h1fff, 16'hA5A5, 1'b0, 16'h0000};
    vecs[5] = '{16'h3fff, 16'h0000, 1'b1, 1'b0, 13'h1fff, 16'h0000, 1'b1, 16'hA5A5};
    vecs[6] = '{16'hA005, 16'h0000, 1'b1, 1'b0, 13'h0005, 16'h0000, 1'b1, 16'hBEEF};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[8] = '{16'h8007, 16'h5555, 1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 16'h0000};

    // Reset state, with a host request present to show outputs stay quiet
    rst_n = 1'b0;
    model_reset();
    set_in(16'h0000, '0, 1'b1, 1'b0, 13'h0005, '0);
    #1;
    chk("rst_sram_ce", sram_ce, 1'b0);
    chk("rst_host_gnt", host_gnt, 1'b0);
    chk("rst_sram_addr", sram_addr, 13'h0);
    chk("rst_core_stall", core_stall, 1'b0);
    chk("rst_core_rvalid", core_rvalid, 1'b0);
    chk("rst_errs", {err_overflow, err_conflict}, 2'b00);
    host_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Conflict: both enables set -> no push, no issue, sticky flag
    set_in(16'h6003, 16'h7777, 1'b0, 1'b0, '0, '0);
    settle(); tick();
    set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("cfl_no_issue", sram_ce, 1'b0);
    chk("cfl_flag", err_conflict, 1'b1);
    tick(); settle(); tick(); settle();
    chk("cfl_sticky", err_conflict, 1'b1);
    tick();

    // Overflow: host holds the port while five core reads arrive
    for (int i = 0; i < 5; i++) begin
      set_in(16'h2000 | 16'(i), '0, 1'b1, 1'b0, 13'h0020, '0);
      settle();
      chk("ovf_stall", core_stall, i == 4);
      tick();
    end
    set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("ovf_flag", err_overflow, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) settle();
      if (core_rvalid) got.push_back(core_rdata);
      tick();
    end
    chk("ovf_rvalid_count", got.size(), 4);
    for (int j = 0; j < 4 && j < got.size(); j++)
      chk("ovf_order", got[j], 16'h1000 + 16'(j));

    // Arbitration: host and core read in the same cycle
    set_in(16'h2008, '0, 1'b1, 1'b0, 13'h0007, '0);
    settle();
    chk("arb_gnt", host_gnt, 1'b1);
    chk("arb_host_addr", sram_addr, 13'h0007);
    tick();
    set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("arb_host_rvalid", host_rvalid, 1'b1);
    chk("arb_host_rdata", host_rdata, 16'h1007);
    chk("arb_core_issue", {sram_ce, sram_we, sram_addr}, {1'b1, 1'b0, 13'h0008});
    tick(); settle();
    chk("arb_core_rvalid", core_rvalid, 1'b1);
    chk("arb_core_rdata", core_rdata, 16'h1008);
    tick();

    // Reset in the cycle after a read issue, asserted between clock edges
    set_in(16'h2003, '0, 1'b0, 1'b0, '0, '0);
    settle(); tick();
    set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("rmr_issue", sram_ce, 1'b1);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rmr_rvalid", core_rvalid, 1'b0);
    chk("rmr_sram", {sram_ce, sram_we, sram_addr, sram_wdata}, '0);
    chk("rmr_errs", {err_overflow, err_conflict}, 2'b00);
    settle(); tick();
    rst_n = 1'b1;
    settle();
    chk("rmr_no_late_rvalid", core_rvalid, 1'b0);
    chk("rmr_fifo_empty", sram_ce, 1'b0);
    tick();

    // Table vectors, each a single core request from an idle queue
    for (int v = 0; v < 9; v++) begin
      set_in(vecs[v].ctrl, vecs[v].wdata, 1'b0, 1'b0, '0, '0);
      settle(); tick();
      set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
      settle();
      chk("vec_ce", sram_ce, vecs[v].e_ce);
      chk("vec_we", sram_we, vecs[v].e_we);
      chk("vec_addr", sram_addr, vecs[v].e_addr);
      if (vecs[v].e_we || !vecs[v].e_ce) chk("vec_wdata", sram_wdata, vecs[v].e_wdata);
      tick(); settle();
      chk("vec_rvalid", core_rvalid, vecs[v].e_rv);
      if (vecs[v].e_rv) chk("vec_rdata", core_rdata, vecs[v].e_rdata);
      tick();
    end

    // Randomized mixed traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      logic [15:0] c;
      int unsigned k;
      k = $urandom_range(0, 9);
      c = 16'($urandom_range(0, 15));
      if (k <= 3)      c = c | 16'h2000;
      else if (k <= 6) c = c | 16'h4000;
      else if (k == 8) c = c | 16'h6000;
      else if (k == 9) c = c | 16'h8000;
      set_in(c, 16'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
             13'($urandom_range(0, 15)), 16'($urandom));
      settle(); tick();
    end
    set_in(16'h0000, '0, 1'b0, 1'b0, '0, '0);
    for (int n = 0; n < 8; n++) begin
      settle(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
